// File: rtl/uart_resp_pkg.sv
// Shared types and defaults for the UART sample responder.
// Holds the FSM encoding, command constants and the sample byte-width helper.
package uart_resp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO
  } state_e;

  localparam logic [7:0] DEF_CMD_BASE = 8'h78;
  localparam logic [7:0] DEF_CMD_ALL  = 8'h61;
  localparam logic [7:0] DEF_HDR      = 8'hA5;
  localparam logic [7:0] DEF_NAK      = 8'h15;

  localparam int WAIT_HI_CYCLES = 4;

  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_resp_serializer.sv
// Snapshot register and frame byte mux for the sample responder.
// Optional trailing XOR checksum byte when CHECKSUM_EN is defined.
module uart_resp_serializer
  import uart_resp_pkg::*;
#(
  parameter int         NUM_CH   = 3,
  parameter int         SAMPLE_W = 16,
  parameter logic [7:0] HDR      = DEF_HDR,
  parameter logic [7:0] NAK      = DEF_NAK
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       load_all,
  input  logic                       load_nak,
  input  logic [2:0]                 load_ch,
  input  logic                       advance,
  input  logic [NUM_CH*SAMPLE_W-1:0] samples,
  output logic [7:0]                 byte_o,
  output logic                       last_o
);

  localparam int NB   = nbytes(SAMPLE_W);
  localparam int NBW  = NB * 8;
  localparam int NTOT = NUM_CH * NB;
  localparam int IW   = $clog2(NTOT + 2);

  logic [NTOT*8-1:0] snap_q, snap_d;
  logic [IW-1:0]     ndata_q, ndata_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              nak_q, nak_d;

  logic [NTOT*8-1:0] padded;
  logic [NBW-1:0]    chan_pad;
  logic [7:0]        data_byte;
  logic [7:0]        ck;
  logic [IW-1:0]     last_idx;

  // Each sample occupies whole bytes; unused top bits stay zero.
  always_comb begin
    padded = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      padded[c*NBW +: SAMPLE_W] = samples[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_comb begin
    chan_pad = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (load_ch == 3'(c)) begin
        chan_pad = padded[c*NBW +: NBW];
      end
    end
  end

  always_comb begin
    snap_d  = snap_q;
    ndata_d = ndata_q;
    nak_d   = nak_q;
    idx_d   = idx_q;
    if (load) begin
      idx_d = '0;
      nak_d = load_nak;
      if (load_nak) begin
        ndata_d = '0;
      end else if (load_all) begin
        snap_d  = padded;
        ndata_d = IW'(NTOT);
      end else begin
        snap_d[NBW-1:0] = chan_pad;
        ndata_d         = IW'(NB);
      end
    end else if (advance) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q  <= '0;
      ndata_q <= '0;
      nak_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      snap_q  <= snap_d;
      ndata_q <= ndata_d;
      nak_q   <= nak_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    data_byte = '0;
    ck        = HDR;
    for (int b = 0; b < NTOT; b++) begin
      if (idx_q == IW'(b + 1)) begin
        data_byte = snap_q[b*8 +: 8];
      end
      if (IW'(b) < ndata_q) begin
        ck = ck ^ snap_q[b*8 +: 8];
      end
    end
  end

  always_comb begin
    last_idx = '0;
    if (!nak_q) begin
`ifdef CHECKSUM_EN
      last_idx = ndata_q + 1'b1;
`else
      last_idx = ndata_q;
`endif
    end
  end

  always_comb begin
    byte_o = ck;
    if (nak_q) begin
      byte_o = NAK;
    end else if (idx_q == '0) begin
      byte_o = HDR;
    end else if (idx_q <= ndata_q) begin
      byte_o = data_byte;
    end
  end

  assign last_o = (idx_q == last_idx);

endmodule

// File: rtl/uart_sample_responder.sv
// Command/response engine: decodes a UART command byte and streams a framed sample reply.
// Define CHECKSUM_EN to append an XOR checksum byte to data frames.
module uart_sample_responder
  import uart_resp_pkg::*;
#(
  parameter int         NUM_CH   = 3,
  parameter int         SAMPLE_W = 16,
  parameter logic [7:0] CMD_BASE = DEF_CMD_BASE,
  parameter logic [7:0] CMD_ALL  = DEF_CMD_ALL,
  parameter logic [7:0] HDR      = DEF_HDR,
  parameter logic [7:0] NAK      = DEF_NAK
) (
  input  logic                       CLK_50,
  input  logic                       areset,
  input  logic                       rx_ready,
  input  logic [7:0]                 rx_data,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic [NUM_CH*SAMPLE_W-1:0] samples,
  output logic [2:0]                 sel_ch,
  output logic                       busy,
  output logic                       cmd_drop
);

  localparam logic [1:0] WCNT_MAX = 2'(WAIT_HI_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [2:0] sel_ch_q, sel_ch_d;
  logic       busy_q, busy_d;
  logic       drop_q, drop_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic       last_q, last_d;

  logic [7:0] off;
  logic       is_all;
  logic       is_ch;
  logic       ld, ld_all, ld_nak, adv;
  logic       ser_last;
  logic [7:0] ser_byte;
  logic       start_o;

  assign off    = rx_data - CMD_BASE;
  assign is_all = (rx_data == CMD_ALL);
  assign is_ch  = (off < 8'(NUM_CH));

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    sel_ch_d  = sel_ch_q;
    busy_d    = busy_q;
    drop_d    = rx_ready && (state_q != S_IDLE);
    wcnt_d    = wcnt_q;
    last_d    = last_q;
    ld        = 1'b0;
    ld_all    = 1'b0;
    ld_nak    = 1'b0;
    adv       = 1'b0;
    start_o   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_ready) begin
          ld      = 1'b1;
          busy_d  = 1'b1;
          state_d = S_LOAD;
          if (is_all) begin
            ld_all = 1'b1;
          end else if (is_ch) begin
            sel_ch_d = off[2:0];
          end else begin
            ld_nak = 1'b1;
          end
        end
      end
      S_LOAD: begin
        tx_data_d = ser_byte;
        state_d   = S_START;
      end
      S_START: begin
        if (!tx_busy) begin
          start_o = 1'b1;
          wcnt_d  = '0;
          state_d = S_WAIT_HI;
        end
      end
      // Index moves on here so the next byte is ready when tx_busy falls.
      S_WAIT_HI: begin
        if (tx_busy || wcnt_q == WCNT_MAX) begin
          last_d  = ser_last;
          adv     = !ser_last;
          state_d = S_WAIT_LO;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            tx_data_d = ser_byte;
            state_d   = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50 or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      tx_data_q <= '0;
      sel_ch_q  <= '0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
      wcnt_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      sel_ch_q  <= sel_ch_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
      wcnt_q    <= wcnt_d;
      last_q    <= last_d;
    end
  end

  uart_resp_serializer #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W),
    .HDR      (HDR),
    .NAK      (NAK)
  ) u_ser (
    .clk      (CLK_50),
    .rst      (areset),
    .load     (ld),
    .load_all (ld_all),
    .load_nak (ld_nak),
    .load_ch  (off[2:0]),
    .advance  (adv),
    .samples  (samples),
    .byte_o   (ser_byte),
    .last_o   (ser_last)
  );

  assign tx_start = start_o;
  assign tx_data  = tx_data_q;
  assign sel_ch   = sel_ch_q;
  assign busy     = busy_q;
  assign cmd_drop = drop_q;

endmodule

// File: tb/tb_uart_sample_responder.sv
// Directed bench for uart_sample_responder with a simple transmitter model.
// Checksum expectations follow CHECKSUM_EN.
module tb_uart_sample_responder;

  logic        CLK_50 = 1'b0;
  logic        areset = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [47:0] samples = '0;
  logic [2:0]  sel_ch;
  logic        busy;
  logic        cmd_drop;

  int ncmp = 0;
  int nfail = 0;

  logic [7:0] txq[$];
  int  nstart = 0;
  int  ndrop = 0;
  int  tx_len = 3;
  int  bcnt = 0;
  bit  pend = 1'b0;

  always #10 CLK_50 = ~CLK_50;

  uart_sample_responder dut (
    .CLK_50   (CLK_50),
    .areset   (areset),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .samples  (samples),
    .sel_ch   (sel_ch),
    .busy     (busy),
    .cmd_drop (cmd_drop)
  );

  // Transmitter: goes busy one cycle after a start for tx_len cycles (0 = instant).
  always @(negedge CLK_50) begin
    if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) tx_busy = 1'b0;
    end
    if (pend) begin
      pend = 1'b0;
      if (tx_len > 0) begin
        tx_busy = 1'b1;
        bcnt = tx_len;
      end
    end
    if (tx_start === 1'b1) begin
      txq.push_back(tx_data);
      nstart++;
      pend = 1'b1;
    end
    if (cmd_drop === 1'b1) ndrop++;
  end

  function automatic logic [7:0] xsum(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    return x;
  endfunction

  task automatic send_rx(input logic [7:0] b);
    @(negedge CLK_50);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge CLK_50);
    rx_ready = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge CLK_50);
      n++;
    end
    ncmp++;
    if (busy !== 1'b0) begin
      nfail++;
      $display("FAIL %s_done: busy=%b after %0d cycles, want 0", nm, busy, n);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) @(negedge CLK_50);
    ncmp++;
    if (tx_start !== 1'b0) begin
      nfail++; $display("FAIL rst_tx_start: got %b want 0", tx_start);
    end
    ncmp++;
    if (tx_data !== 8'h00) begin
      nfail++; $display("FAIL rst_tx_data: got %h want 00", tx_data);
    end
    ncmp++;
    if (sel_ch !== 3'd0) begin
      nfail++; $display("FAIL rst_sel_ch: got %0d want 0", sel_ch);
    end
    ncmp++;
    if (busy !== 1'b0) begin
      nfail++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    ncmp++;
    if (cmd_drop !== 1'b0) begin
      nfail++; $display("FAIL rst_cmd_drop: got %b want 0", cmd_drop);
    end
    areset = 1'b0;
    repeat (2) @(negedge CLK_50);
  endtask

  task automatic test_single();
    logic [7:0] exp[$];
    logic [7:0] got;
    samples = {16'h0000, 16'hBEEF, 16'h0000};
    tx_len = 3;
    txq.delete();
    send_rx(8'h79);
    ncmp++;
    if (sel_ch !== 3'd1) begin
      nfail++; $display("FAIL single_sel_ch: got %0d want 1", sel_ch);
    end
    @(negedge CLK_50);
    ncmp++;
    if (tx_start !== 1'b1) begin
      nfail++; $display("FAIL single_latency: tx_start=%b want 1", tx_start);
    end
    ncmp++;
    if (busy !== 1'b1) begin
      nfail++; $display("FAIL single_busy: got %b want 1", busy);
    end
    wait_done("single");
    exp = '{8'hA5, 8'hEF, 8'hBE};
`ifdef CHECKSUM_EN
    exp.push_back(xsum(exp));
`endif
    ncmp++;
    if (txq.size() != exp.size()) begin
      nfail++; $display("FAIL single_len: got %0d want %0d", txq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < txq.size()) ? txq[i] : 8'hxx;
      ncmp++;
      if (got !== exp[i]) begin
        nfail++; $display("FAIL single_b%0d: got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_all();
    logic [7:0] exp[$];
    logic [7:0] got;
    samples = {16'h0506, 16'h0304, 16'h0102};
    tx_len = 2;
    txq.delete();
    nstart = 0;
    send_rx(8'h61);
    wait_done("all");
    exp = '{8'hA5, 8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05};
`ifdef CHECKSUM_EN
    exp.push_back(xsum(exp));
`endif
    ncmp++;
    if (nstart != exp.size()) begin
      nfail++; $display("FAIL all_starts: got %0d want %0d", nstart, exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < txq.size()) ? txq[i] : 8'hxx;
      ncmp++;
      if (got !== exp[i]) begin
        nfail++; $display("FAIL all_b%0d: got %h want %h", i, got, exp[i]);
      end
    end
    ncmp++;
    if (sel_ch !== 3'd1) begin
      nfail++; $display("FAIL all_sel_ch: got %0d want 1", sel_ch);
    end
  endtask

  task automatic test_nak();
    tx_len = 0;
    txq.delete();
    send_rx(8'h41);
    wait_done("nak");
    ncmp++;
    if (txq.size() != 1) begin
      nfail++; $display("FAIL nak_len: got %0d want 1", txq.size());
    end
    ncmp++;
    if (txq.size() > 0 && txq[0] !== 8'h15) begin
      nfail++; $display("FAIL nak_byte: got %h want 15", txq[0]);
    end
    ncmp++;
    if (sel_ch !== 3'd1) begin
      nfail++; $display("FAIL nak_sel_ch: got %0d want 1", sel_ch);
    end
  endtask

  task automatic test_drop();
    logic [7:0] exp[$];
    logic [7:0] got;
    samples = {16'h7777, 16'h6666, 16'hCAFE};
    tx_len = 3;
    txq.delete();
    ndrop = 0;
    send_rx(8'h78);
    send_rx(8'h7A);
    samples = 48'h0;
    wait_done("drop");
    ncmp++;
    if (ndrop != 1) begin
      nfail++; $display("FAIL drop_count: got %0d want 1", ndrop);
    end
    ncmp++;
    if (sel_ch !== 3'd0) begin
      nfail++; $display("FAIL drop_sel_ch: got %0d want 0", sel_ch);
    end
    exp = '{8'hA5, 8'hFE, 8'hCA};
`ifdef CHECKSUM_EN
    exp.push_back(xsum(exp));
`endif
    ncmp++;
    if (txq.size() != exp.size()) begin
      nfail++; $display("FAIL drop_len: got %0d want %0d", txq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < txq.size()) ? txq[i] : 8'hxx;
      ncmp++;
      if (got !== exp[i]) begin
        nfail++; $display("FAIL drop_b%0d: got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_checksum();
    logic [7:0] exp[$];
    logic [7:0] got;
    samples = {16'h1234, 16'h0000, 16'h0000};
    tx_len = 1;
    txq.delete();
    send_rx(8'h7A);
    wait_done("ck");
    exp = '{8'hA5, 8'h34, 8'h12};
`ifdef CHECKSUM_EN
    exp.push_back(8'h83);
`endif
    ncmp++;
    if (txq.size() != exp.size()) begin
      nfail++; $display("FAIL ck_len: got %0d want %0d", txq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < txq.size()) ? txq[i] : 8'hxx;
      ncmp++;
      if (got !== exp[i]) begin
        nfail++; $display("FAIL ck_b%0d: got %h want %h", i, got, exp[i]);
      end
    end
    ncmp++;
    if (sel_ch !== 3'd2) begin
      nfail++; $display("FAIL ck_sel_ch: got %0d want 2", sel_ch);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[$];
    logic [7:0] got;
    int n = 0;
    samples = {16'h0000, 16'h0000, 16'h5AC3};
    tx_len = 4;
    txq.delete();
    nstart = 0;
    send_rx(8'h7A);
    while (nstart < 2 && n < 200) begin
      @(negedge CLK_50);
      n++;
    end
    ncmp++;
    if (nstart < 2) begin
      nfail++; $display("FAIL rmid_2nd_start: starts=%0d want 2", nstart);
    end
    #1 areset = 1'b1;
    #1;
    ncmp++;
    if (tx_start !== 1'b0) begin
      nfail++; $display("FAIL rmid_tx_start: got %b want 0", tx_start);
    end
    ncmp++;
    if (busy !== 1'b0) begin
      nfail++; $display("FAIL rmid_busy: got %b want 0", busy);
    end
    ncmp++;
    if (sel_ch !== 3'd0) begin
      nfail++; $display("FAIL rmid_sel_ch: got %0d want 0", sel_ch);
    end
    @(negedge CLK_50);
    areset = 1'b0;
    repeat (8) @(negedge CLK_50);
    txq.delete();
    send_rx(8'h78);
    wait_done("rmid");
    exp = '{8'hA5, 8'hC3, 8'h5A};
`ifdef CHECKSUM_EN
    exp.push_back(xsum(exp));
`endif
    ncmp++;
    if (txq.size() != exp.size()) begin
      nfail++; $display("FAIL rmid_len: got %0d want %0d", txq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < txq.size()) ? txq[i] : 8'hxx;
      ncmp++;
      if (got !== exp[i]) begin
        nfail++; $display("FAIL rmid_b%0d: got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all();
    test_nak();
    test_drop();
    test_checksum();
    test_reset_mid();
    repeat (4) @(negedge CLK_50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
